mandel_scan: RTL
================

MANDEL_SCAN -- requirements
Module: mandel_scan

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- W, 32, coordinate width, Q4.28 signed.
- H_RES, 640, pixels per row.
- V_RES, 480, rows per frame.
- AW, 19, pixel address width; SHALL satisfy 2^AW >= H_RES*V_RES.

REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle request to render a frame.
- cx0  in  W  real coordinate of column 0.
- cy0  in  W  imaginary coordinate of row 0.
- dx  in  W  per-column step.
- dy  in  W  per-row step.
- max_it_in  in  16  iteration limit.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last pixel is written.
- core_start  out  1  start request to the iteration core.
- core_cx  out  W  point real part.
- core_cy  out  W  point imaginary part.
- core_max_it  out  16  latched iteration limit.
- core_iter  in  16  iteration count from the core.
- core_idle  in  1  core idle flag (high = idle, result valid).
- pix_addr  out  AW  linear pixel address, row*H_RES+col.
- pix_data  out  16  pixel value.
- pix_we  out  1  write strobe.
- pix_ready  in  1  sink accepts a write when high while pix_we is high.

Function
REQ-003 The FSM SHALL have six states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, WRITE, ADVANCE.
REQ-004 In IDLE, frame_start=1 SHALL latch cx0, cy0, dx, dy and max_it_in; set col=0, row=0, core_cx=cx0, core_cy=cy0, pix_addr=0, busy=1; and go to ISSUE.
REQ-005 In ISSUE, core_start SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT_ACK.
REQ-006 WAIT_ACK SHALL hold core_start=0 until core_idle=0, then go to WAIT_DONE; core_idle's one-cycle lag after start SHALL NOT be taken as completion.
REQ-007 WAIT_DONE SHALL hold until core_idle=1, then capture core_iter into a result register and go to WRITE.
REQ-008 In WRITE, pix_we SHALL be 1 with pix_addr and pix_data held stable until pix_ready=1; on that handshake cycle the FSM SHALL go to ADVANCE and pix_we SHALL be 0 the following cycle.
REQ-009 ADVANCE behaviour:
- If col<H_RES-1: col+=1, core_cx+=dx.
- Else: col=0, core_cx=cx0 (latched), row+=1, core_cy+=dy.
- pix_addr+=1 in both cases.
- The FSM SHALL then go to ISSUE, except on the last pixel (col=H_RES-1, row=V_RES-1), where it SHALL go to IDLE with busy=0 and frame_done=1 for one cycle.
REQ-010 Coordinate sums SHALL be W-bit two's complement with silent wrap-around; there is no saturation.
REQ-011 frame_start while busy=1 SHALL be ignored, and latched frame parameters SHALL NOT change mid-frame.
REQ-012 core_cx, core_cy and core_max_it SHALL be stable from ISSUE through WAIT_DONE.
REQ-013 Each pixel SHALL take 4 overhead cycles plus core latency plus pix_ready stall cycles.

Reset
REQ-014 reset=1 SHALL, at the next rising edge and from any state, force:
- IDLE state;
- busy, frame_done, core_start and pix_we to 0;
- pix_addr, pix_data, core_cx, core_cy, core_max_it, col and row to 0.
REQ-015 Reset mid-frame SHALL abandon the frame with no frame_done pulse; an in-flight core result SHALL be discarded.

Configuration
REQ-016 Macro MANDEL_SCAN_COLOR_EN SHALL select the pixel format:
- Defined: pix_data = 16'h0000 when the captured iter >= latched max_it; otherwise an RGB565 value {iter[4:0], iter[5:0], iter[4:0]}.
- Undefined: pix_data = the raw captured iter.

Verification
REQ-017 Every bench SHALL use a behavioural core model (idle drops 1 cycle after start, rises N cycles later) and cover:
- H_RES=4, V_RES=2, cx0=0xE0000000, dx=0x08000000, cy0=0xF0000000, dy=0x10000000 -> core_cx per pixel E0000000, E8000000, F0000000, F8000000, repeating on row 1; core_cy = F0000000 (row 0), 00000000 (row 1); pix_addr 0..7; one frame_done.
- Core model returns iter=pixel index+3 -> pix_data 3..10, in order, with the macro undefined.
- pix_ready held low 5 cycles on pixel 2 -> pix_we high 6 cycles, pix_addr=2 and pix_data constant, no pixel skipped or duplicated.
- frame_start pulsed again at pixel 3 -> ignored; exactly 8 writes and one frame_done.
- reset asserted in WAIT_DONE of pixel 5 -> next cycle busy=0, pix_we=0, pix_addr=0; no frame_done; a new frame renders correctly.
- Macro defined, max_it=16, iter=16 -> pix_data=0x0000; iter=5 -> pix_data=0x28A5.

Source files
------------

// File: rtl/mandel_scan.sv
// mandel_scan: raster scan sequencer for an external Mandelbrot iteration core.
// Walks every pixel of an H_RES x V_RES frame, issues the pixel coordinate to
// the core, waits for its result and writes it to a pixel sink with a
// ready/valid style handshake.
//
// Build option: define MANDEL_SCAN_COLOR_EN to emit RGB565 pixels (black for
// points that reached the iteration limit); otherwise the raw iteration count
// is written.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | no frame in progress, waiting for frame_start
// S_ISSUE    | core_start high for this single cycle
// S_WAIT_ACK | waiting for the core to drop idle (start accepted)
// S_WAIT_DONE| waiting for the core to return to idle (result valid)
// S_WRITE    | pix_we high, holding address/data until pix_ready
// S_ADVANCE  | step column/row and coordinates, finish frame on last pixel

module mandel_scan #(
  parameter int W     = 32,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int AW    = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic [W-1:0]  cx0,
  input  logic [W-1:0]  cy0,
  input  logic [W-1:0]  dx,
  input  logic [W-1:0]  dy,
  input  logic [15:0]   max_it_in,
  output logic          busy,
  output logic          frame_done,
  output logic          core_start,
  output logic [W-1:0]  core_cx,
  output logic [W-1:0]  core_cy,
  output logic [15:0]   core_max_it,
  input  logic [15:0]   core_iter,
  input  logic          core_idle,
  output logic [AW-1:0] pix_addr,
  output logic [15:0]   pix_data,
  output logic          pix_we,
  input  logic          pix_ready
);

  localparam int CW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int RW = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_WRITE,
    S_ADVANCE
  } state_t;

  state_t          state_q;
  logic [W-1:0]    cx0_q, dx_q, dy_q;
  logic [W-1:0]    core_cx_q, core_cy_q;
  logic [15:0]     core_max_it_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic [AW-1:0]   pix_addr_q;
  logic [15:0]     pix_data_q;
  logic            busy_q, frame_done_q, core_start_q, pix_we_q;

  logic [15:0]     pix_val_d;
  logic            col_last_d, last_pix_d;

  // Pixel format applied to the core result as it is captured.
  always_comb begin
`ifdef MANDEL_SCAN_COLOR_EN
    if (core_iter >= core_max_it_q) pix_val_d = 16'h0000;
    else                            pix_val_d = {core_iter[4:0], core_iter[5:0], core_iter[4:0]};
`else
    pix_val_d = core_iter;
`endif
  end

  // End-of-row and end-of-frame detection for the advance step.
  always_comb begin
    col_last_d = (col_q == CW'(H_RES - 1));
    last_pix_d = col_last_d && (row_q == RW'(V_RES - 1));
  end

  // Scan FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      core_start_q  <= 1'b0;
      pix_we_q      <= 1'b0;
      pix_addr_q    <= '0;
      pix_data_q    <= '0;
      core_cx_q     <= '0;
      core_cy_q     <= '0;
      core_max_it_q <= '0;
      col_q         <= '0;
      row_q         <= '0;
      cx0_q         <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            cx0_q         <= cx0;
            dx_q          <= dx;
            dy_q          <= dy;
            core_max_it_q <= max_it_in;
            core_cx_q     <= cx0;
            core_cy_q     <= cy0;
            col_q         <= '0;
            row_q         <= '0;
            pix_addr_q    <= '0;
            busy_q        <= 1'b1;
            core_start_q  <= 1'b1;
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          core_start_q <= 1'b0;
          state_q      <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // the core still reports idle in the cycle right after start
          if (!core_idle) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (core_idle) begin
            pix_data_q <= pix_val_d;
            pix_we_q   <= 1'b1;
            state_q    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (pix_ready) begin
            pix_we_q <= 1'b0;
            state_q  <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          pix_addr_q <= pix_addr_q + AW'(1);
          if (col_last_d) begin
            col_q     <= '0;
            core_cx_q <= cx0_q;
            row_q     <= row_q + RW'(1);
            core_cy_q <= core_cy_q + dy_q;
          end else begin
            col_q     <= col_q + CW'(1);
            core_cx_q <= core_cx_q + dx_q;
          end
          if (last_pix_d) begin
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            core_start_q <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign core_start  = core_start_q;
  assign core_cx     = core_cx_q;
  assign core_cy     = core_cy_q;
  assign core_max_it = core_max_it_q;
  assign pix_addr    = pix_addr_q;
  assign pix_data    = pix_data_q;
  assign pix_we      = pix_we_q;

endmodule
